// File: rtl/bist_sram_pkg.sv
// Shared widths and types for the BIST SRAM and its MBIST controller.
package bist_sram_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;
endpackage

// File: rtl/bist_sram_array.sv
// Storage array with synchronous write and asynchronous read port.
// The registered output lives in the top, so a foundry macro can replace this.
module sram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/bist_sram.sv
// Single-port synchronous SRAM, read-first, one-cycle registered read data.
import bist_sram_pkg::*;

module bist_sram #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ramaddr,
  input  logic [DATA_W-1:0] ramin,
  input  logic              we,
  output logic [DATA_W-1:0] ramout
);
  logic [DATA_W-1:0] rdata;
  logic              wr_en;

  // Writes are dropped on any edge that sees reset asserted.
  assign wr_en = we & ~rst;

  sram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk   (clk),
    .addr  (ramaddr),
    .wdata (ramin),
    .wr_en (wr_en),
    .rdata (rdata)
  );

  // Sampling the combinational read before the array update gives read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ramout <= '0;
    else     ramout <= rdata;
  end
endmodule

// File: tb/tb_bist_sram.sv
// Scoreboard bench for bist_sram: expectations queued per driven cycle, checked after the edge.
module tb_bist_sram;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ramaddr = '0;
  logic [7:0] ramin = '0;
  logic       we = 1'b0;
  logic [7:0] ramout;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit         vld;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bist_sram dut (
    .clk     (clk),
    .rst     (rst),
    .ramaddr (ramaddr),
    .ramin   (ramin),
    .we      (we),
    .ramout  (ramout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs, queue what ramout must show after the edge, then compare.
  task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic w,
                       input bit v, input logic [7:0] e, input string t);
    exp_t ent;
    ramaddr = a;
    ramin   = d;
    we      = w;
    sb.push_back('{vld: v, exp: e, tag: t});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      ent = sb.pop_front();
      if (ent.vld) chk(ent.tag, ramout, ent.exp);
    end
  endtask

  initial begin
    #2;
    chk("reset_state", ramout, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // async reset clears a held value with no clock edge
    drive(8'd1, 8'hA5, 1'b1, 0, 8'h00, "");
    drive(8'd1, 8'h00, 1'b0, 1, 8'hA5, "pre_rst");
    rst = 1'b1;
    #1;
    chk("rst_async", ramout, 8'h00);
    #2;
    rst = 1'b0;
    drive(8'd10, 8'h3C, 1'b1, 0, 8'h00, "");
    drive(8'd10, 8'h00, 1'b0, 1, 8'h3C, "post_rst_rd");

    // full sweep
    for (int i = 0; i < 256; i++)
      drive(i[7:0], i[7:0], 1'b1, 0, 8'h00, "");
    for (int i = 0; i < 256; i++)
      drive(i[7:0], 8'h00, 1'b0, 1, i[7:0], "sweep");

    // boundary addresses
    drive(8'd0,   8'hFF, 1'b1, 0, 8'h00, "");
    drive(8'd255, 8'h00, 1'b1, 0, 8'h00, "");
    drive(8'd0,   8'h00, 1'b0, 1, 8'hFF, "bnd_addr0");
    drive(8'd255, 8'h00, 1'b0, 1, 8'h00, "bnd_addr255");
    drive(8'd0,   8'h00, 1'b0, 1, 8'hFF, "bnd_alias");

    // read-during-write returns old data
    drive(8'd5, 8'h11, 1'b1, 0, 8'h00, "");
    drive(8'd5, 8'h22, 1'b1, 1, 8'h11, "rdw_old");
    drive(8'd5, 8'h00, 1'b0, 1, 8'h22, "rdw_new");

    // back-to-back and hold
    drive(8'd7, 8'h55, 1'b1, 0, 8'h00, "");
    drive(8'd8, 8'hAA, 1'b1, 0, 8'h00, "");
    drive(8'd7, 8'h00, 1'b0, 1, 8'h55, "b2b_7a");
    drive(8'd8, 8'h00, 1'b0, 1, 8'hAA, "b2b_8");
    drive(8'd7, 8'h00, 1'b0, 1, 8'h55, "b2b_7b");
    for (int i = 0; i < 3; i++)
      drive(8'd7, 8'h00, 1'b0, 1, 8'h55, "hold");

    // reset during a write drops the write
    drive(8'd20, 8'h01, 1'b1, 0, 8'h00, "");
    rst = 1'b1;
    drive(8'd20, 8'hFE, 1'b1, 1, 8'h00, "rst_mid");
    rst = 1'b0;
    drive(8'd20, 8'h00, 1'b0, 1, 8'h01, "rst_mid_drop");

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
